// File: rtl/fir_output_collector.sv
// fir_output_collector: FWFT sample FIFO with overflow/drop statistics and alarm FSM
//   in:  clk, rst_n (async, active-low), in_data/in_valid/in_ovf (push-only stream),
//        m_ready (sink accept), clr_stats (sync statistics/alarm clear)
//   out: m_data/m_ovf/m_valid (FIFO head), fifo_level, drop_count, ovf_count,
//        alarm_state (00 NORMAL, 01 WARN, 10 ALARM), alarm_irq (pulse on ALARM entry)
module fir_output_collector #(
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int CONSEC_WARN  = 4,
  parameter int CONSEC_ALARM = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  input  logic                            in_ovf,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_ovf,
  output logic                            m_valid,
  input  logic                            m_ready,
  input  logic                            clr_stats,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]            drop_count,
  output logic [CNT_WIDTH-1:0]            ovf_count,
  output logic [1:0]                      alarm_state,
  output logic                            alarm_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CONSEC_ALARM + 1);
  typedef enum logic [1:0] {NORMAL = 2'b00, WARN = 2'b01, ALARM = 2'b10} state_t;
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d, ovf_q, ovf_d;
  logic [CW-1:0] consec_q, consec_d;
  state_t state_q, state_d;
  logic irq_q, irq_d;
  logic full, pop, push, drop;
  logic [DATA_WIDTH:0] head;
  assign full       = level_q == LW'(FIFO_DEPTH);
  assign m_valid    = level_q != '0;
  assign head       = mem_q[rd_ptr_q];
  assign m_data     = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_ovf      = m_valid & head[DATA_WIDTH];
  assign pop        = m_valid & m_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign push       = in_valid & (~full | pop);
  assign drop       = in_valid & full & ~pop;
  assign fifo_level = level_q;
  assign drop_count = drop_q;
  assign ovf_count  = ovf_q;
  assign alarm_state = state_q;
  assign alarm_irq  = irq_q;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    drop_d   = clr_stats ? '0 : drop_q + CNT_WIDTH'(drop && drop_q != '1);
    ovf_d    = clr_stats ? '0 : ovf_q + CNT_WIDTH'(in_valid && in_ovf && ovf_q != '1);
    consec_d = clr_stats ? '0 :
               !in_valid ? consec_q :
               !in_ovf   ? '0 :
               consec_q + CW'(consec_q != CW'(CONSEC_ALARM));
    state_d  = state_q;
    if (clr_stats) state_d = NORMAL;
    else if (state_q != ALARM && consec_d >= CW'(CONSEC_ALARM)) state_d = ALARM;
    else if (state_q == NORMAL && consec_d >= CW'(CONSEC_WARN)) state_d = WARN;
    else if (state_q == WARN && in_valid && !in_ovf) state_d = NORMAL;
    irq_d    = state_d == ALARM && state_q != ALARM;
  end
  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= {in_ovf, in_data};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= '0;
      consec_q <= '0;
      state_q  <= NORMAL;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      consec_q <= consec_d;
      state_q  <= state_d;
      irq_q    <= irq_d;
    end
  end
endmodule

// File: tb/tb_fir_output_collector.sv
// tb_fir_output_collector: directed self-checking bench for fir_output_collector
module tb_fir_output_collector;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic in_valid = 1'b0, in_ovf = 1'b0, m_ready = 1'b0, clr_stats = 1'b0;
  logic [15:0] m_data, drop_count, ovf_count;
  logic m_ovf, m_valid, alarm_irq;
  logic [4:0] fifo_level;
  logic [1:0] alarm_state;
  int tests = 0, fails = 0;
  fir_output_collector dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ovf(in_ovf),
    .m_data(m_data), .m_ovf(m_ovf), .m_valid(m_valid), .m_ready(m_ready),
    .clr_stats(clr_stats), .fifo_level(fifo_level), .drop_count(drop_count),
    .ovf_count(ovf_count), .alarm_state(alarm_state), .alarm_irq(alarm_irq)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_mvalid"}, 32'(m_valid), 0);
    chk({tag, "_mdata"}, 32'(m_data), 0);
    chk({tag, "_movf"}, 32'(m_ovf), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_drop"}, 32'(drop_count), 0);
    chk({tag, "_ovfcnt"}, 32'(ovf_count), 0);
    chk({tag, "_state"}, 32'(alarm_state), 0);
    chk({tag, "_irq"}, 32'(alarm_irq), 0);
  endtask
  initial begin
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // basic flow
    m_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h1234; step;
    chk("flow0_data", 32'(m_data), 32'h1234);
    chk("flow0_valid", 32'(m_valid), 1);
    chk("flow0_level", 32'(fifo_level), 1);
    in_data = 16'h8000; step;
    chk("flow1_data", 32'(m_data), 32'h8000);
    chk("flow1_level", 32'(fifo_level), 1);
    in_data = 16'h7FFF; step;
    chk("flow2_data", 32'(m_data), 32'h7FFF);
    chk("flow2_ovf", 32'(m_ovf), 0);
    in_valid = 1'b0; step;
    chk("flow_empty_valid", 32'(m_valid), 0);
    chk("flow_empty_level", 32'(fifo_level), 0);
    // fill and drop
    m_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 16'h0100 + 16'(i);
      step;
    end
    in_valid = 1'b0;
    chk("fill_level", 32'(fifo_level), 16);
    chk("fill_drop", 32'(drop_count), 4);
    chk("fill_head", 32'(m_data), 32'h0100);
    in_valid = 1'b1; in_data = 16'hABCD; m_ready = 1'b1; step;
    in_valid = 1'b0; m_ready = 1'b0;
    chk("fullpp_level", 32'(fifo_level), 16);
    chk("fullpp_drop", 32'(drop_count), 4);
    chk("fullpp_head", 32'(m_data), 32'h0101);
    // drain in order
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(m_data), i < 15 ? 32'h0101 + 32'(i) : 32'hABCD);
      step;
    end
    chk("drain_valid", 32'(m_valid), 0);
    chk("drain_level", 32'(fifo_level), 0);
    // WARN then recover
    in_valid = 1'b1; in_ovf = 1'b1; in_data = 16'h0EEE;
    step; step; step;
    chk("warn3_state", 32'(alarm_state), 0);
    step;
    chk("warn4_state", 32'(alarm_state), 1);
    chk("warn4_ovfcnt", 32'(ovf_count), 4);
    chk("warn4_movf", 32'(m_ovf), 1);
    in_ovf = 1'b0; step;
    chk("recover_state", 32'(alarm_state), 0);
    chk("recover_consec", 32'(dut.consec_q), 0);
    chk("recover_ovfcnt", 32'(ovf_count), 4);
    // ALARM via overflows separated by idle gaps
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_ovf = 1'b1; step;
      if (i == 15) chk("alarm15_state", 32'(alarm_state), 1);
      if (i == 15) chk("alarm15_irq", 32'(alarm_irq), 0);
      in_valid = 1'b0; in_ovf = 1'b0;
      if (i == 16) begin
        chk("alarm16_state", 32'(alarm_state), 2);
        chk("alarm16_irq", 32'(alarm_irq), 1);
      end
      step;
    end
    chk("alarm_irq_pulse", 32'(alarm_irq), 0);
    chk("alarm_hold_state", 32'(alarm_state), 2);
    chk("alarm_ovfcnt", 32'(ovf_count), 20);
    in_valid = 1'b1; in_ovf = 1'b0;
    for (int i = 0; i < 5; i++) step;
    in_valid = 1'b0;
    chk("sticky_state", 32'(alarm_state), 2);
    chk("sticky_consec", 32'(dut.consec_q), 0);
    chk("sticky_irq", 32'(alarm_irq), 0);
    step;
    chk("pre_clr_level", 32'(fifo_level), 0);
    // clear priority over a simultaneous overflowed push
    m_ready = 1'b0;
    in_valid = 1'b1; in_ovf = 1'b1; in_data = 16'h5555; clr_stats = 1'b1; step;
    in_valid = 1'b0; in_ovf = 1'b0; clr_stats = 1'b0;
    chk("clr_ovfcnt", 32'(ovf_count), 0);
    chk("clr_drop", 32'(drop_count), 0);
    chk("clr_state", 32'(alarm_state), 0);
    chk("clr_consec", 32'(dut.consec_q), 0);
    chk("clr_level", 32'(fifo_level), 1);
    chk("clr_mdata", 32'(m_data), 32'h5555);
    chk("clr_movf", 32'(m_ovf), 1);
    // async reset in the middle of a burst
    in_valid = 1'b1; in_ovf = 1'b1; in_data = 16'h0A0A;
    step; step; step;
    chk("burst_level", 32'(fifo_level), 4);
    chk("burst_ovfcnt", 32'(ovf_count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    in_valid = 1'b0; in_ovf = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
